// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: edge-detected UART receive byte FIFO with level, threshold, overrun and optional idle timeout
// Ports: clk/rst (sync active-high), BCLK baud tick (timeout only), rx_done/rx_byte from receiver,
//   rd_en pop strobe, ovr_clr overrun clear; rd_data/rd_valid registered pop result,
//   empty/full/count/rx_irq level status, overrun sticky drop flag, rx_timeout idle flag.
// Optional: define UART_RX_TIMEOUT_EN to build the BCLK idle timeout.
module uart_rx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 8,
  parameter int ADDR_W = 3,
  parameter int THRESH = 4,
  parameter int TIMEOUT_TICKS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              BCLK,
  input  logic              rx_done,
  input  logic [DATA_W-1:0] rx_byte,
  input  logic              rd_en,
  input  logic              ovr_clr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overrun,
  output logic              rx_irq,
  output logic              rx_timeout
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic done_q, push, pop, wr_ok, drop;
  assign empty = count == '0;
  assign full = count == (ADDR_W+1)'(DEPTH);
  assign rx_irq = count >= (ADDR_W+1)'(THRESH);
  assign push = rx_done & ~done_q;
  assign pop = rd_en & ~empty;
  assign wr_ok = push & (~full | pop);
  assign drop = push & full & ~pop;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      rd_data <= '0;
      rd_valid <= 1'b0;
      overrun <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= rx_done;
      if (wr_ok) begin
        mem[wr_ptr] <= rx_byte;
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (pop) begin
        rd_data <= mem[rd_ptr];
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      rd_valid <= pop;
      count <= count + (ADDR_W+1)'(wr_ok) - (ADDR_W+1)'(pop);
      overrun <= drop | (overrun & ~ovr_clr);
    end
  end
`ifdef UART_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  logic [TW-1:0] idle;
  always_ff @(posedge clk) begin
    if (rst) begin
      idle <= '0;
      rx_timeout <= 1'b0;
    end else begin
      idle <= (wr_ok | pop | empty) ? '0 : (BCLK && idle != TW'(TIMEOUT_TICKS)) ? idle + TW'(1) : idle;
      rx_timeout <= (pop | empty) ? 1'b0 : (idle == TW'(TIMEOUT_TICKS)) ? 1'b1 : rx_timeout;
    end
  end
`else
  logic unused_bclk;
  assign unused_bclk = BCLK ^ (TIMEOUT_TICKS == 0);
  assign rx_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: vector table, directed corners and random traffic against a queue model
module tb_uart_rx_fifo;
  logic clk = 0, rst, BCLK, rx_done, rd_en, ovr_clr;
  logic [7:0] rx_byte, rd_data;
  logic rd_valid, empty, full, overrun, rx_irq, rx_timeout;
  logic [3:0] count;
  int checks = 0, errors = 0;
  logic [7:0] q[$];
  logic m_prev, m_ovr, m_rdv;
  logic [7:0] m_rdd;
  typedef struct {logic d; logic [7:0] b; logic r; logic [3:0] ecnt; logic erdv; logic [7:0] erdd;} vec_t;
  vec_t tv[11];
  logic [7:0] last;
  always #5 clk = ~clk;
  uart_rx_fifo dut (.clk(clk), .rst(rst), .BCLK(BCLK), .rx_done(rx_done), .rx_byte(rx_byte),
    .rd_en(rd_en), .ovr_clr(ovr_clr), .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty),
    .full(full), .count(count), .overrun(overrun), .rx_irq(rx_irq), .rx_timeout(rx_timeout));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic cyc(input logic d, input logic [7:0] b, input logic r, input logic c, input logic rs);
    bit push, pop;
    rx_done = d; rx_byte = b; rd_en = r; ovr_clr = c; rst = rs; BCLK = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    if (rs) begin
      q.delete(); m_prev = 0; m_ovr = 0; m_rdv = 0; m_rdd = 0;
    end else begin
      push = d && !m_prev;
      pop = r && q.size() > 0;
      m_prev = d;
      m_rdv = pop;
      if (pop) m_rdd = q.pop_front();
      if (push && q.size() == 8) m_ovr = 1;
      else if (c) m_ovr = 0;
      if (push && q.size() < 8) q.push_back(b);
    end
    chk("count", count, q.size());
    chk("empty", empty, q.size() == 0);
    chk("full", full, q.size() == 8);
    chk("rx_irq", rx_irq, q.size() >= 4);
    chk("overrun", overrun, m_ovr);
    chk("rd_valid", rd_valid, m_rdv);
    chk("rd_data", rd_data, m_rdd);
    chk("rx_timeout", rx_timeout, 0);
  endtask
  task automatic push_b(input logic [7:0] b);
    cyc(1, b, 0, 0, 0);
    cyc(0, b, 0, 0, 0);
  endtask
  task automatic pop_one();
    cyc(0, 0, 1, 0, 0);
  endtask
  initial begin
    tv[0] = '{1, 8'h55, 0, 1, 0, 8'h00};
    tv[1] = '{0, 8'h00, 0, 1, 0, 8'h00};
    tv[2] = '{1, 8'hA3, 0, 2, 0, 8'h00};
    tv[3] = '{0, 8'h00, 0, 2, 0, 8'h00};
    tv[4] = '{1, 8'h0F, 0, 3, 0, 8'h00};
    tv[5] = '{0, 8'h00, 0, 3, 0, 8'h00};
    tv[6] = '{0, 8'h00, 1, 2, 1, 8'h55};
    tv[7] = '{0, 8'h00, 1, 1, 1, 8'hA3};
    tv[8] = '{0, 8'h00, 1, 0, 1, 8'h0F};
    tv[9] = '{0, 8'h00, 1, 0, 0, 8'h0F};
    tv[10] = '{0, 8'h00, 0, 0, 0, 8'h0F};
    cyc(0, 0, 0, 0, 1);
    chk("reset empty", empty, 1);
    chk("reset count", count, 0);
    for (int i = 0; i < 11; i++) begin
      cyc(tv[i].d, tv[i].b, tv[i].r, 0, 0);
      chk("vec count", count, tv[i].ecnt);
      chk("vec rd_valid", rd_valid, tv[i].erdv);
      chk("vec rd_data", rd_data, tv[i].erdd);
    end
    for (int i = 0; i < 20; i++) cyc(1, 8'h7E, 0, 0, 0);
    chk("held level count", count, 1);
    cyc(0, 0, 1, 0, 0);
    chk("held level data", rd_data, 8'h7E);
    for (int i = 0; i < 8; i++) begin
      push_b(8'(i));
      chk("fill irq", rx_irq, i >= 3);
    end
    chk("fill full", full, 1);
    push_b(8'hFF);
    chk("drop overrun", overrun, 1);
    chk("drop count", count, 8);
    for (int i = 0; i < 8; i++) begin
      pop_one();
      chk("drain data", rd_data, 8'(i));
    end
    chk("drain empty", empty, 1);
    cyc(0, 0, 0, 1, 0);
    chk("ovr_clr", overrun, 0);
    for (int i = 0; i < 8; i++) push_b(8'h10 + 8'(i));
    cyc(1, 8'h99, 1, 0, 0);
    chk("full push+pop count", count, 8);
    chk("full push+pop overrun", overrun, 0);
    chk("full push+pop data", rd_data, 8'h10);
    for (int i = 0; i < 8; i++) begin
      pop_one();
      last = rd_data;
    end
    chk("0x99 read last", last, 8'h99);
    cyc(1, 8'h42, 1, 0, 0);
    chk("empty push+pop rd_valid", rd_valid, 0);
    chk("empty push+pop count", count, 1);
    pop_one();
    chk("empty push+pop data", rd_data, 8'h42);
    for (int i = 0; i < 20; i++) begin
      cyc(1, 8'hC0 + 8'(i), 0, 0, 0);
      cyc(0, 0, 1, 0, 0);
      chk("wrap data", rd_data, 8'hC0 + 8'(i));
    end
    for (int i = 0; i < 5; i++) push_b(8'h20 + 8'(i));
    chk("pre-reset count", count, 5);
    cyc(1, 8'hEE, 1, 0, 1);
    chk("mid reset count", count, 0);
    chk("mid reset empty", empty, 1);
    push_b(8'h3C);
    pop_one();
    chk("post reset data", rd_data, 8'h3C);
    for (int i = 0; i < 3000; i++)
      cyc(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 2) == 0,
          $urandom_range(0, 15) == 0, $urandom_range(0, 199) == 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side buffer directly downstream of the UART receiver. It detects each completed character on the receiver's done/out outputs and pushes the byte into a circular FIFO. The FIFO is drained by the APB register block through a single-cycle read strobe. It also provides level, threshold and overrun status for the interrupt and status registers.

Parameters:
DATA_W, 8, width of one received character (matches receiver out width)
DEPTH, 8, number of FIFO entries; power of two, minimum 2
ADDR_W, 3, log2(DEPTH); pointer width
THRESH, 4, fill level at or above which rx_irq asserts; range 1..DEPTH
TIMEOUT_TICKS, 32, BCLK ticks of inactivity before rx_timeout (optional feature only)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous active-high reset
BCLK  input  1  baud tick from baud generator, one clk wide (used only by optional feature)
rx_done  input  1  receiver done flag; level signal, may stay high across several clk
rx_byte  input  DATA_W  receiver out bus; valid when rx_done rises
rd_en  input  1  pop request from APB block
ovr_clr  input  1  clears sticky overrun flag
rd_data  output  DATA_W  popped byte, registered
rd_valid  output  1  one-cycle pulse, rd_data valid
empty  output  1  count == 0
full  output  1  count == DEPTH
count  output  ADDR_W+1  current fill level, 0..DEPTH
overrun  output  1  sticky: byte dropped because FIFO was full
rx_irq  output  1  count >= THRESH
rx_timeout  output  1  idle timeout flag (0 when feature compiled out)

Behaviour:
- Reset (rst=1 at clk edge): wr_ptr=0, rd_ptr=0, count=0, rd_data=0, rd_valid=0, overrun=0, rx_timeout=0, internal done_q=0. Storage array is not reset.
- Outputs after reset: empty=1, full=0, rx_irq=0.
- rst has priority over every other input. A push or pop in the reset cycle is discarded.
- Push detect: done_q <= rx_done every cycle. push = rx_done & ~done_q, i.e. one push per 0->1 edge of rx_done. A level held high never pushes twice.
- Push accepted when ~full, or when full and a pop is accepted in the same cycle:
  - mem[wr_ptr] <= rx_byte
  - wr_ptr <= wr_ptr+1, wrapping modulo DEPTH
- Push when full with no pop: byte dropped, pointers and count unchanged, overrun <= 1.
- Pop accepted when rd_en & ~empty:
  - rd_data <= mem[rd_ptr]
  - rd_ptr <= rd_ptr+1, wrapping
  - rd_valid <= 1 in the next cycle, so latency is 1 clk
- rd_en on empty: ignored, rd_valid=0, rd_data holds its last value.
- Count update: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Simultaneous push and pop on empty: the push is accepted and the pop is ignored. No bypass, so the byte is readable from the next cycle.
- Simultaneous push and pop on full: both are accepted, count stays DEPTH, overrun is not set.
- overrun: sticky. Cleared by ovr_clr. If ovr_clr and a new drop occur in the same cycle, set wins.
- empty, full and rx_irq are combinational decodes of the registered count.

Optional Feature:
Macro UART_RX_TIMEOUT_EN.
- Defined:
  - An idle counter of width $clog2(TIMEOUT_TICKS+1) increments on each BCLK while count != 0.
  - The counter resets to 0 on any accepted push or pop, and whenever count == 0.
  - When the counter reaches TIMEOUT_TICKS it saturates and rx_timeout <= 1.
  - rx_timeout clears on the next accepted pop, or when the FIFO becomes empty.
- Undefined: no counter is built, rx_timeout is tied to 0, and BCLK is unused.

Test Plan:
- Reset, then push 0x55: three rx_done edges carrying 0x55, 0xA3, 0x0F. Expect count=3 and empty=0. Then rd_en three times; expect rd_valid pulses with rd_data 0x55, 0xA3, 0x0F in order, and empty=1 afterwards.
- Held level: rx_done held high for 20 clk with rx_byte=0x7E -> exactly one push, count=1.
- Fill and overrun: 8 pushes 0x00..0x07 -> full=1, rx_irq=1 from the 4th push. 9th push 0xFF -> dropped and overrun=1. Draining reads back 0x00..0x07 with no 0xFF. ovr_clr -> overrun=0.
- Simultaneous events:
  - At count=8, push 0x99 with rd_en in the same cycle -> count stays 8, overrun=0, and 0x99 is read last.
  - At count=0, push with rd_en -> rd_valid=0, count=1.
- Wrap and mid-operation reset: 20 alternating push/pop pairs across the pointer wrap -> data order is preserved. Assert rst with count=5 -> count=0, empty=1 next cycle, and a subsequent push/pop of 0x3C returns 0x3C.
- UART_RX_TIMEOUT_EN defined: one byte held in the FIFO and 32 BCLK ticks elapse -> rx_timeout=1. One pop -> rx_timeout=0. A push at tick 31 restarts the count, with no timeout until 32 more ticks.
